mul_seq_param: RTL and testbench

Parametrised sequential shift-and-add multiplier with a start/busy/done handshake. It replaces the fixed 16-bit repeated-addition multiplier datapath/controller pair. It adds a WIDTH parameter, a full-width 2*WIDTH product, per-operation signed/unsigned mode, synchronous reset and a fixed latency independent of operand values. It sits as a slave compute unit: a sequencer presents operands with `start`, waits for `done`, then reads `product`.

---
 rtl/mul_pkg.sv | 15 +
 rtl/mul_seq_ctrl.sv | 65 ++++++
 rtl/mul_seq_param.sv | 73 +++++++
 tb/tb_mul_seq_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and helpers for the sequential multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  // Counter must hold WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequencing FSM and iteration counter for mul_seq_param
module mul_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cnt_last,
  output logic          load,
  output logic          step,
  output logic          fix,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt
);
  import mul_pkg::*;

  state_t state, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != IDLE);
      done  <= fix;
      if (load) begin
        cnt <= CW'(WIDTH);
      end else if (step) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_last) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        fix     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/mul_seq_param.sv
// rtl/mul_seq_param.sv - parametrised shift-and-add multiplier with start/busy/done handshake
module mul_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  import mul_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] mcand, mult, acc;
  logic             neg;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             load, step, fix, cnt_last;
  logic [CW-1:0]    cnt;

  mul_seq_ctrl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cnt_last (cnt_last),
    .load     (load),
    .step     (step),
    .fix      (fix),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt)
  );

  assign cnt_last = (cnt == CW'(1));

  // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  assign sum = {1'b0, acc} + (mult[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mult    <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      if (load) begin
        mcand <= a_mag;
        mult  <= b_mag;
        acc   <= '0;
        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (step) begin
        acc  <= sum[WIDTH:1];
        mult <= {sum[0], mult[WIDTH-1:1]};
      end
      if (fix) begin
        product <= neg ? -{acc, mult} : {acc, mult};
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_param.sv
// tb/tb_mul_seq_param.sv - directed and randomised checks of mul_seq_param at WIDTH 16, 8 and 32
module tb_mul_seq_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start16 = 1'b0, s16 = 1'b0, busy16, done16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] product16;

  logic        start8 = 1'b0, s8 = 1'b0, busy8, done8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] product8;

  logic        start32 = 1'b0, s32 = 1'b0, busy32, done32;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] product32;

  int n_checks = 0;
  int n_errors = 0;

  mul_seq_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .is_signed(s16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(product16));

  mul_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8));

  mul_seq_param #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .is_signed(s32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .product(product32));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input int w, input logic sgn,
                                       input logic [63:0] x, input logic [63:0] y);
    logic [63:0] ex, ey, p;
    ex = x;
    ey = y;
    if (sgn && x[w-1]) ex = x | (~64'd0 << w);
    if (sgn && y[w-1]) ey = y | (~64'd0 << w);
    p = ex * ey;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  task automatic run16(input string tag, input logic sgn, input logic [15:0] x,
                       input logic [15:0] y, input logic [31:0] exp);
    int lat, bcnt;
    @(negedge clk);
    s16 = sgn; a16 = x; b16 = y; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = ~x; b16 = ~y;
    bcnt = busy16 ? 1 : 0;
    lat = 0;
    while (!done16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy16) bcnt++;
    end
    check({tag, " latency"}, 64'(lat), 64'd17);
    check({tag, " busy cycles"}, 64'(bcnt), 64'd17);
    check({tag, " product"}, 64'(product16), 64'(exp));
  endtask

  task automatic run8(input string tag, input logic sgn, input logic [7:0] x,
                      input logic [7:0] y, input logic [15:0] exp);
    int lat;
    @(negedge clk);
    s8 = sgn; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~x; b8 = ~y;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd9);
    check({tag, " product"}, 64'(product8), 64'(exp));
  endtask

  task automatic run32(input string tag, input logic sgn, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] exp);
    int lat;
    @(negedge clk);
    s32 = sgn; a32 = x; b32 = y; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; a32 = ~x; b32 = ~y;
    lat = 0;
    while (!done32 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " product"}, product32, exp);
  endtask

  initial begin
    int lat, d1, d2, ndone;
    logic [63:0] rx, ry, rexp;
    logic rs;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy16), 64'd0);
    check("reset done", 64'(done16), 64'd0);
    check("reset product", 64'(product16), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run16("u ff*101", 1'b0, 16'h00FF, 16'h0101, 32'h0000FFFF);
    run16("u max", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run16("u zero", 1'b0, 16'h1234, 16'h0000, 32'h00000000);
    run16("s -1*1", 1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF);
    run16("s min*min", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    run16("s min*max", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000);
    run16("u ffff*1", 1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF);

    // start pulses mid-CALC and during SIGN must be ignored
    @(negedge clk);
    s16 = 1'b0; a16 = 16'd3; b16 = 16'd5; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'd100; b16 = 16'd100;
    lat = 0;
    ndone = 0;
    while (!done16 && lat < 40) begin
      start16 = (lat == 5 || lat == 16);
      @(posedge clk); #1;
      lat++;
    end
    start16 = 1'b0;
    check("ignore latency", 64'(lat), 64'd17);
    check("ignore product", 64'(product16), 64'd15);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done16 || busy16) ndone++;
    end
    check("ignore no extra op", 64'(ndone), 64'd0);

    // start held high: back-to-back ops every WIDTH+2 cycles
    @(negedge clk);
    s16 = 1'b0; a16 = 16'd2; b16 = 16'd3; start16 = 1'b1;
    @(posedge clk); #1;
    d1 = 0;
    d2 = 0;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk); #1;
      if (done16) begin
        if (d1 == 0) begin
          d1 = t;
          a16 = 16'd4; b16 = 16'd5;
        end else if (d2 == 0) begin
          d2 = t;
        end
      end
      if (t == 26) check("hold product between dones", 64'(product16), 64'd6);
    end
    start16 = 1'b0;
    check("hold first done", 64'(d1), 64'd17);
    check("hold issue interval", 64'(d2 - d1), 64'd18);
    check("hold second product", 64'(product16), 64'd20);
    repeat (20) @(posedge clk);

    // reset at CALC cycle 8 aborts silently
    @(negedge clk);
    s16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", 64'(busy16), 64'd0);
    check("abort done", 64'(done16), 64'd0);
    check("abort product", 64'(product16), 64'd0);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done16) ndone++;
    end
    check("abort no done", 64'(ndone), 64'd0);
    run16("after abort", 1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA);

    run8("w8 s min*min", 1'b1, 8'h80, 8'h80, 16'h4000);
    run8("w8 u max", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    for (int i = 0; i < 1000; i++) begin
      rs = 1'($urandom_range(0, 1));
      rx = 64'($urandom) & 64'hFF;
      ry = 64'($urandom) & 64'hFF;
      rexp = model(8, rs, rx, ry);
      run8("w8 rand", rs, rx[7:0], ry[7:0], rexp[15:0]);
    end

    run32("w32 s min*min", 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    run32("w32 u max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    for (int i = 0; i < 1000; i++) begin
      rs = 1'($urandom_range(0, 1));
      rx = 64'($urandom);
      ry = 64'($urandom);
      rexp = model(32, rs, rx, ry);
      run32("w32 rand", rs, rx[31:0], ry[31:0], rexp);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
